// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: column/row counters with registered sync,
// active-video and line/frame start strobes, all aligned to the shown pixel.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        H_POL    = 1'b0,
    parameter logic        V_POL    = 1'b0,
    parameter int unsigned CW       = 10
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          EN,
    output logic          H_Sync,
    output logic          V_Sync,
    output logic          Active,
    output logic [CW-1:0] CountCol,
    output logic [CW-1:0] CountRow,
    output logic          Line_Start,
    output logic          Frame_Start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // Decode bounds carry one spare bit so a sync ending at 2^CW still compares correctly
    localparam logic [CW:0] H_ACT_END  = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] H_SYNC_BEG = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] H_SYNC_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_ACT_END  = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] V_SYNC_BEG = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] V_SYNC_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          act_q, act_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;

    logic [CW:0]   col_x;
    logic [CW:0]   row_x;

    // Next-count plus decode of the next pixel, so every output lands with its count
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        act_d = act_q;
        ls_d  = 1'b0;
        fs_d  = 1'b0;
        col_x = '0;
        row_x = '0;
        if (EN) begin
            if (col_q == H_LAST) begin
                col_d = '0;
                row_d = (row_q == V_LAST) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            col_x = {1'b0, col_d};
            row_x = {1'b0, row_d};
            hs_d  = (col_x >= H_SYNC_BEG && col_x < H_SYNC_END) ? H_POL : ~H_POL;
            vs_d  = (row_x >= V_SYNC_BEG && row_x < V_SYNC_END) ? V_POL : ~V_POL;
            act_d = (col_x < H_ACT_END) && (row_x < V_ACT_END);
            ls_d  = (col_d == '0);
            fs_d  = (col_d == '0) && (row_d == '0);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            col_q <= H_LAST;
            row_q <= V_LAST;
            hs_q  <= ~H_POL;
            vs_q  <= ~V_POL;
            act_q <= 1'b0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            act_q <= act_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
        end
    end

    assign CountCol    = col_q;
    assign CountRow    = row_q;
    assign H_Sync      = hs_q;
    assign V_Sync      = vs_q;
    assign Active      = act_q;
    assign Line_Start  = ls_q;
    assign Frame_Start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny positive-polarity
// mode, each checked every cycle against an independent raster model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic       ls;
        logic       fs;
        logic [9:0] col;
        logic [9:0] row;
    } obs_t;

    typedef struct packed {
        int   ha; int hf; int hsw; int hb;
        int   va; int vf; int vsw; int vb;
        logic hp; logic vp;
    } mode_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1;
    logic en_a = 1'b0, en_b = 1'b0;

    logic       hs_a, vs_a, act_a, ls_a, fs_a;
    logic [9:0] col_a, row_a;
    logic       hs_b, vs_b, act_b, ls_b, fs_b;
    logic [3:0] col_b, row_b;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_a (
        .CLK(clk), .RST_N(rst_a), .EN(en_a),
        .H_Sync(hs_a), .V_Sync(vs_a), .Active(act_a),
        .CountCol(col_a), .CountRow(row_a),
        .Line_Start(ls_a), .Frame_Start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CW(4)
    ) u_dut_b (
        .CLK(clk), .RST_N(rst_b), .EN(en_b),
        .H_Sync(hs_b), .V_Sync(vs_b), .Active(act_b),
        .CountCol(col_b), .CountRow(row_b),
        .Line_Start(ls_b), .Frame_Start(fs_b)
    );

    obs_t obs [2];
    assign obs[0] = {hs_a, vs_a, act_a, ls_a, fs_a, col_a, row_a};
    assign obs[1] = {hs_b, vs_b, act_b, ls_b, fs_b, 10'(col_b), 10'(row_b)};

    int    errors = 0;
    int    checks = 0;
    obs_t  sbq [2][$];
    mode_t md [2];
    int    m_col [2];
    int    m_row [2];
    bit    m_ls [2];
    bit    m_fs [2];
    int    since_ls [2];
    int    since_fs [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int h_total(input int d);
        return md[d].ha + md[d].hf + md[d].hsw + md[d].hb;
    endfunction

    function automatic int v_total(input int d);
        return md[d].va + md[d].vf + md[d].vsw + md[d].vb;
    endfunction

    function automatic obs_t model_out(input int d);
        obs_t o;
        int   hsb, vsb;
        hsb   = md[d].ha + md[d].hf;
        vsb   = md[d].va + md[d].vf;
        o.col = 10'(m_col[d]);
        o.row = 10'(m_row[d]);
        o.hs  = (m_col[d] >= hsb && m_col[d] < hsb + md[d].hsw) ? md[d].hp : ~md[d].hp;
        o.vs  = (m_row[d] >= vsb && m_row[d] < vsb + md[d].vsw) ? md[d].vp : ~md[d].vp;
        o.act = (m_col[d] < md[d].ha) && (m_row[d] < md[d].va);
        o.ls  = m_ls[d];
        o.fs  = m_fs[d];
        return o;
    endfunction

    task automatic model_reset(input int d);
        m_col[d]    = h_total(d) - 1;
        m_row[d]    = v_total(d) - 1;
        m_ls[d]     = 1'b0;
        m_fs[d]     = 1'b0;
        since_ls[d] = -1;
        since_fs[d] = -1;
        sbq[d].push_back(model_out(d));
    endtask

    task automatic model_step(input int d, input bit en);
        if (en) begin
            if (m_col[d] == h_total(d) - 1) begin
                m_col[d] = 0;
                m_row[d] = (m_row[d] == v_total(d) - 1) ? 0 : m_row[d] + 1;
            end else begin
                m_col[d]++;
            end
            m_ls[d] = (m_col[d] == 0);
            m_fs[d] = (m_col[d] == 0) && (m_row[d] == 0);
        end else begin
            m_ls[d] = 1'b0;
            m_fs[d] = 1'b0;
        end
        sbq[d].push_back(model_out(d));
    endtask

    task automatic compare(input int d);
        obs_t exp;
        if (sbq[d].size() == 0) begin
            check_eq(d == 0 ? "a_sb_empty" : "b_sb_empty", 32'd0, 32'd1);
        end else begin
            exp = sbq[d].pop_front();
            check_eq(d == 0 ? "a_pixel" : "b_pixel", 32'(obs[d]), 32'(exp));
        end
    endtask

    task automatic track_periods(input int d, input bit en);
        if (en) begin
            if (since_ls[d] >= 0) since_ls[d]++;
            if (since_fs[d] >= 0) since_fs[d]++;
        end
        if (obs[d].ls) begin
            if (since_ls[d] > 0) check_eq("line_period", since_ls[d], h_total(d));
            since_ls[d] = 0;
        end
        if (obs[d].fs) begin
            if (since_fs[d] > 0) check_eq("frame_period", since_fs[d], h_total(d) * v_total(d));
            since_fs[d] = 0;
        end
    endtask

    // One clock for both instances; inputs change 1 time unit after the edge
    task automatic step(input bit ea, input bit eb);
        en_a = ea;
        en_b = eb;
        model_step(0, ea);
        model_step(1, eb);
        @(posedge clk);
        #1;
        compare(0);
        compare(1);
        track_periods(0, ea);
        track_periods(1, eb);
    endtask

    // Asynchronous reset mid-cycle, held across one edge with EN high, then released
    task automatic hit_reset(input int d);
        int other;
        other = 1 - d;
        #2;
        if (d == 0) rst_a = 1'b0; else rst_b = 1'b0;
        #1;
        model_reset(d);
        compare(d);
        if (d == 0) begin en_a = 1'b1; en_b = 1'b0; end
        else        begin en_b = 1'b1; en_a = 1'b0; end
        model_reset(d);
        model_step(other, 1'b0);
        @(posedge clk);
        #1;
        compare(0);
        compare(1);
        if (d == 0) rst_a = 1'b1; else rst_b = 1'b1;
    endtask

    initial begin
        int guard;
        md[0] = '{ha: 640, hf: 16, hsw: 96, hb: 48, va: 480, vf: 10, vsw: 2, vb: 33, hp: 1'b0, vp: 1'b0};
        md[1] = '{ha: 8, hf: 2, hsw: 3, hb: 1, va: 4, vf: 1, vsw: 1, vb: 1, hp: 1'b1, vp: 1'b1};

        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #10;
        model_reset(0);
        model_reset(1);
        compare(0);
        compare(1);
        check_eq("rst_col", 32'(col_a), 32'd799);
        check_eq("rst_row", 32'(row_a), 32'd524);
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;

        step(1'b1, 1'b1);
        check_eq("first_fs", 32'(fs_a), 32'd1);
        check_eq("first_act", 32'(act_a), 32'd1);
        step(1'b1, 1'b1);
        check_eq("second_col", 32'(col_a), 32'd1);

        repeat (654) step(1'b1, 1'b1);
        check_eq("pre_freeze_col", 32'(col_a), 32'd655);
        repeat (5) step(1'b0, 1'b1);
        check_eq("frozen_col", 32'(col_a), 32'd655);
        step(1'b1, 1'b1);
        check_eq("resume_col", 32'(col_a), 32'd656);
        check_eq("resume_hsync", 32'(hs_a), 32'd0);

        repeat (1800) step(1'b1, 1'b1);

        repeat (400) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        guard = 0;
        while (m_col[0] != 300 && guard < 1000) begin
            step(1'b1, 1'b1);
            guard++;
        end
        check_eq("reach_col300", 32'(m_col[0] == 300), 32'd1);
        hit_reset(0);
        step(1'b1, 1'b1);
        check_eq("restart_fs", 32'(fs_a), 32'd1);
        check_eq("restart_col", 32'(col_a), 32'd0);

        guard = 0;
        while (!(m_row[1] == 3 && m_col[1] == 5) && guard < 200) begin
            step(1'b1, 1'b1);
            guard++;
        end
        check_eq("reach_b_mid", 32'(m_row[1] == 3 && m_col[1] == 5), 32'd1);
        hit_reset(1);
        step(1'b1, 1'b1);
        check_eq("b_restart_fs", 32'(fs_b), 32'd1);

        repeat (300) step(1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
